can_muxbus_master: RTL and testbench

CAN_MUXBUS_MASTER -- requirements
Module: can_muxbus_master

---
 rtl/can_bus_pkg.sv | 38 +++
 rtl/can_int_sync.sv | 24 ++
 rtl/can_muxbus_master.sv | 186 ++++++++++++++++++
 tb/tb_can_muxbus_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_bus_pkg.sv
// Shared definitions for the multiplexed-bus CAN controller master: FSM states,
// default timing constants and small sizing helpers.
package can_bus_pkg;

    typedef enum logic [2:0] {
        RST_PULSE,
        IDLE,
        ADDR,
        AHOLD,
        STROBE,
        CSHOLD,
        RECOVER
    } bus_state_t;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_T_ALE      = 3;
    localparam int DEF_T_AH       = 1;
    localparam int DEF_T_STB      = 4;
    localparam int DEF_T_REC      = 2;
    localparam int DEF_RST_CYCLES = 256;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The one shared counter must hold the longest phase, including the reset pulse.
    function automatic int cnt_width(input int a, input int b, input int c,
                                     input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/can_int_sync.sv
// Two-flop synchroniser turning the asynchronous active-low CAN interrupt lines
// into active-high interrupt requests in the clk domain.
module can_int_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_n,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= ~async_n;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/can_muxbus_master.sv
// Master for CAN controllers sharing a multiplexed 8-bit AD bus (ALE, CS_n, RD_n, WR_n).
// Define CAN_MUXBUS_HWRST_EN to drive a timed bus_rst_n pulse after every reset.
module can_muxbus_master
    import can_bus_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int T_ALE      = DEF_T_ALE,
    parameter int T_AH       = DEF_T_AH,
    parameter int T_STB      = DEF_T_STB,
    parameter int T_REC      = DEF_T_REC,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [ch_width(NUM_CH)-1:0]   req_ch,
    input  logic [7:0]                    req_addr,
    input  logic [7:0]                    req_wdata,
    output logic                          rsp_valid,
    output logic [7:0]                    rsp_rdata,
    input  logic [7:0]                    bus_ad_i,
    output logic [7:0]                    bus_ad_o,
    output logic                          bus_ad_oe,
    output logic                          bus_ale,
    output logic [NUM_CH-1:0]             bus_cs_n,
    output logic                          bus_rd_n,
    output logic                          bus_wr_n,
    input  logic [NUM_CH-1:0]             bus_int_n,
    output logic [NUM_CH-1:0]             irq_o,
    output logic                          bus_rst_n
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = cnt_width(RST_CYCLES, T_ALE, T_AH, T_STB, T_REC);

    bus_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   ch_q;
    logic              wr_q;
    logic              ch_ok;
    logic [7:0]        wdata_q;
    logic [NUM_CH-1:0] sel_n;

    assign req_ready = (state == IDLE);

    always_comb begin
        sel_n = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_q) == i) sel_n[i] = 1'b0;
        end
    end

`ifndef CAN_MUXBUS_HWRST_EN
    assign bus_rst_n = 1'b1;
`endif

    // Every phase loads the shared counter on entry and leaves when it reaches zero;
    // outputs are registered alongside the transition so they change with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef CAN_MUXBUS_HWRST_EN
            state     <= RST_PULSE;
            bus_rst_n <= 1'b0;
`else
            state     <= IDLE;
`endif
            cnt       <= '0;
            ch_q      <= '0;
            wr_q      <= 1'b0;
            ch_ok     <= 1'b0;
            wdata_q   <= '0;
            bus_cs_n  <= '1;
            bus_rd_n  <= 1'b1;
            bus_wr_n  <= 1'b1;
            bus_ale   <= 1'b0;
            bus_ad_o  <= '0;
            bus_ad_oe <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
`ifdef CAN_MUXBUS_HWRST_EN
                RST_PULSE: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        bus_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                IDLE: begin
                    if (req_valid) begin
                        ch_q    <= req_ch;
                        wr_q    <= req_wr;
                        wdata_q <= req_wdata;
                        // An unpopulated channel is answered at once without touching the bus.
                        if (int'(req_ch) < NUM_CH) begin
                            ch_ok     <= 1'b1;
                            state     <= ADDR;
                            cnt       <= CNT_W'(T_ALE - 1);
                            bus_ale   <= 1'b1;
                            bus_ad_o  <= req_addr;
                            bus_ad_oe <= 1'b1;
                        end else begin
                            ch_ok <= 1'b0;
                            state <= CSHOLD;
                        end
                    end
                end
                ADDR: begin
                    if (cnt == '0) begin
                        state    <= AHOLD;
                        cnt      <= CNT_W'(T_AH - 1);
                        bus_ale  <= 1'b0;
                        bus_cs_n <= sel_n;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                AHOLD: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= CNT_W'(T_STB - 1);
                        if (wr_q) begin
                            bus_wr_n  <= 1'b0;
                            bus_ad_o  <= wdata_q;
                            bus_ad_oe <= 1'b1;
                        end else begin
                            bus_rd_n  <= 1'b0;
                            bus_ad_o  <= '0;
                            bus_ad_oe <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state    <= CSHOLD;
                        bus_rd_n <= 1'b1;
                        bus_wr_n <= 1'b1;
                        if (!wr_q) rsp_rdata <= bus_ad_i;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CSHOLD: begin
                    bus_cs_n  <= '1;
                    bus_ad_o  <= '0;
                    bus_ad_oe <= 1'b0;
                    rsp_valid <= 1'b1;
                    if (wr_q || !ch_ok) rsp_rdata <= '0;
                    if (T_REC == 0) begin
                        state <= IDLE;
                    end else begin
                        state <= RECOVER;
                        cnt   <= CNT_W'(T_REC - 1);
                    end
                end
                RECOVER: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    can_int_sync #(
        .WIDTH(NUM_CH)
    ) u_int_sync (
        .clk     (clk),
        .rst     (rst),
        .async_n (bus_int_n),
        .sync_out(irq_o)
    );

endmodule

// File: tb/tb_can_muxbus_master.sv
// Self-checking bench for can_muxbus_master: directed and random accesses scored
// against per-transaction expectations derived from the bus timing parameters.
module tb_can_muxbus_master;

    localparam int NUM_CH     = 3;
    localparam int T_ALE      = 3;
    localparam int T_AH       = 1;
    localparam int T_STB      = 4;
    localparam int T_REC      = 2;
    localparam int RST_CYCLES = 256;
    localparam int LAT_FULL   = T_ALE + T_AH + T_STB + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [1:0]        req_ch = '0;
    logic [7:0]        req_addr = '0;
    logic [7:0]        req_wdata = '0;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic [7:0]        bus_ad_i;
    logic [7:0]        bus_ad_o;
    logic              bus_ad_oe;
    logic              bus_ale;
    logic [NUM_CH-1:0] bus_cs_n;
    logic              bus_rd_n;
    logic              bus_wr_n;
    logic [NUM_CH-1:0] bus_int_n = '1;
    logic [NUM_CH-1:0] irq_o;
    logic              bus_rst_n;

    logic [7:0] rdVal = 8'h00;
    int checkCnt = 0;
    int passCnt = 0;
    int cyc = 0;

    // The controller model drives the read value only while RD_n is low.
    assign bus_ad_i = bus_rd_n ? ~rdVal : rdVal;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    can_muxbus_master #(
        .NUM_CH(NUM_CH), .T_ALE(T_ALE), .T_AH(T_AH), .T_STB(T_STB),
        .T_REC(T_REC), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_ch(req_ch), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .bus_ad_i(bus_ad_i), .bus_ad_o(bus_ad_o), .bus_ad_oe(bus_ad_oe),
        .bus_ale(bus_ale), .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n),
        .bus_wr_n(bus_wr_n), .bus_int_n(bus_int_n), .irq_o(irq_o),
        .bus_rst_n(bus_rst_n)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus-wide safety rules, checked whenever the bus is active.
    always @(negedge clk) begin
        if (!rst && (bus_cs_n != '1 || !bus_rd_n || !bus_wr_n)) begin
            checkOutput("cs_onehot", 32'($countones(~bus_cs_n) <= 1), 32'd1);
            checkOutput("strobe_excl", 32'(!(!bus_rd_n && !bus_wr_n)), 32'd1);
        end
    end

    task automatic waitReady(input string tag);
        int k;
        k = 0;
        while (!req_ready && k < 600) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 32'(req_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic wr, input int ch, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] rdv);
        bit ok;
        int aleCnt, csCnt, wrongCs, wrCnt, rdCnt, rspCnt, lat;
        logic [7:0] rdata;
        ok = (ch < NUM_CH);
        aleCnt = 0; csCnt = 0; wrongCs = 0; wrCnt = 0; rdCnt = 0; rspCnt = 0;
        lat = -1; rdata = 8'h00;
        @(negedge clk);
        waitReady("ready_wait");
        rdVal     = rdv;
        req_valid = 1'b1;
        req_wr    = wr;
        req_ch    = 2'(ch);
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_ale && bus_ad_oe && bus_ad_o == addr) aleCnt++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!bus_cs_n[i]) begin
                    if (i == ch) csCnt++;
                    else wrongCs++;
                end
            end
            if (!bus_wr_n && bus_ad_oe && bus_ad_o == wdata) wrCnt++;
            if (!bus_rd_n && !bus_ad_oe && bus_ad_o == 8'h00) rdCnt++;
            if (ok && wr && c == T_ALE + T_AH + T_STB)
                checkOutput("cshold_data", {22'd0, bus_wr_n, bus_ad_oe, bus_ad_o},
                            {22'd0, 1'b1, 1'b1, wdata});
            if (rsp_valid) begin
                rspCnt++;
                if (lat < 0) begin
                    lat = c;
                    rdata = rsp_rdata;
                end
            end
        end
        checkOutput("ale_cycles", 32'(aleCnt), ok ? 32'(T_ALE) : 32'd0);
        checkOutput("cs_cycles", 32'(csCnt), ok ? 32'(T_AH + T_STB + 1) : 32'd0);
        checkOutput("cs_wrong", 32'(wrongCs), 32'd0);
        checkOutput("wr_cycles", 32'(wrCnt), (ok && wr) ? 32'(T_STB) : 32'd0);
        checkOutput("rd_cycles", 32'(rdCnt), (ok && !wr) ? 32'(T_STB) : 32'd0);
        checkOutput("rsp_count", 32'(rspCnt), 32'd1);
        checkOutput("latency", 32'(lat), ok ? 32'(LAT_FULL) : 32'd1);
        checkOutput("rdata", 32'(rdata), (ok && !wr) ? 32'(rdv) : 32'd0);
    endtask

    task automatic backToBack();
        int acc[2];
        int rsp[2];
        int n, r;
        n = 0; r = 0;
        acc[0] = -100; acc[1] = -100; rsp[0] = -100; rsp[1] = -100;
        @(negedge clk);
        waitReady("b2b_ready");
        rdVal     = 8'h3C;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_ch    = 2'd0;
        req_addr  = 8'h11;
        req_wdata = 8'h99;
        for (int c = 0; c < 60 && r < 2; c++) begin
            if (rsp_valid) begin
                rsp[r] = cyc;
                r++;
            end
            if (req_valid && req_ready && n < 2) begin
                acc[n] = cyc + 1;
                n++;
                @(posedge clk);
                #1;
                if (n == 1) begin
                    req_wr   = 1'b0;
                    req_ch   = 2'd1;
                    req_addr = 8'h22;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(n), 32'd2);
        checkOutput("b2b_rsps", 32'(r), 32'd2);
        checkOutput("b2b_lat1", 32'(rsp[0] - acc[0]), 32'(LAT_FULL));
        checkOutput("b2b_gap", 32'(acc[1] - rsp[0]), 32'(T_REC + 1));
        checkOutput("b2b_lat2", 32'(rsp[1] - acc[1]), 32'(LAT_FULL));
    endtask

    task automatic resetInStrobe();
        int rspSeen;
        rspSeen = 0;
        @(negedge clk);
        waitReady("rst_ready");
        rdVal     = 8'h5A;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_ch    = 2'd2;
        req_addr  = 8'h44;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c <= T_ALE + T_AH + 1; c++) @(negedge clk);
        checkOutput("rst_pre_strobe", 32'(bus_rd_n), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_abort_bus",
                    {26'd0, bus_rd_n, bus_wr_n, bus_ale, bus_ad_oe, bus_cs_n == '1, rsp_valid},
                    {26'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        rst = 1'b0;
        for (int c = 0; c < 600 && !req_ready; c++) begin
            if (rsp_valid) rspSeen++;
            @(negedge clk);
        end
        checkOutput("rst_no_rsp", 32'(rspSeen), 32'd0);
        checkOutput("rst_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic irqPulse(input int ch);
        logic [NUM_CH-1:0] mask;
        mask = '0;
        mask[ch] = 1'b1;
        @(negedge clk);
        bus_int_n = ~mask;
        @(negedge clk);
        checkOutput("irq_lat1", 32'(irq_o), 32'd0);
        @(negedge clk);
        checkOutput("irq_lat2", 32'(irq_o), 32'(mask));
        bus_int_n = '1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("irq_clear", 32'(irq_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lowCnt, readyHigh;
        repeat (3) @(negedge clk);
        checkOutput("reset_cs", 32'(bus_cs_n), 32'((1 << NUM_CH) - 1));
        checkOutput("reset_strobes", {30'd0, bus_rd_n, bus_wr_n}, 32'd3);
        checkOutput("reset_ad", {22'd0, bus_ale, bus_ad_oe, bus_ad_o}, 32'd0);
        checkOutput("reset_rsp", {23'd0, rsp_valid, rsp_rdata}, 32'd0);
        checkOutput("reset_irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
`ifdef CAN_MUXBUS_HWRST_EN
        lowCnt = 0;
        readyHigh = 0;
        while (!bus_rst_n && lowCnt < 1000) begin
            lowCnt++;
            if (req_ready) readyHigh++;
            @(negedge clk);
        end
        checkOutput("hwrst_low_cycles", 32'(lowCnt), 32'(RST_CYCLES));
        checkOutput("hwrst_ready_low", 32'(readyHigh), 32'd0);
        checkOutput("hwrst_ready_after", 32'(req_ready), 32'd1);
`else
        lowCnt = 0;
        readyHigh = 0;
        @(negedge clk);
        checkOutput("bus_rst_n_tied", 32'(bus_rst_n), 32'd1);
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
`endif
        irqPulse(1);

        applyStimulus(1'b1, 1, 8'h0A, 8'h5C, 8'h00);
        applyStimulus(1'b0, 0, 8'h02, 8'h00, 8'hA7);
        applyStimulus(1'b0, 3, 8'h33, 8'h00, 8'hC3);
        applyStimulus(1'b1, 2, 8'hFF, 8'h00, 8'h00);
        backToBack();

        for (int t = 0; t < 12; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          8'($urandom), 8'($urandom), 8'($urandom));
        end

        irqPulse(int'($urandom_range(0, NUM_CH - 1)));
        resetInStrobe();
        applyStimulus(1'b0, 2, 8'h7E, 8'h00, 8'h81);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
